// File: rtl/memory_cycle_if.sv
// Data-memory request/acknowledge port between the M stage and data memory.
// The master issues a held request; the slave answers with a one-cycle ack.
interface memory_cycle_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/memory_cycle.sv
// M pipeline stage: runs loads/stores over a variable-latency req/ack port,
// stalls the front of the pipe while an access is in flight, and registers the W bundle.
module memory_cycle #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RD_M,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] ALU_ResultM,
    memory_cycle_if.master    mem,
    output logic              StallM,
    output logic              mem_err,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RD_W,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [DATA_W-1:0] ALU_ResultW,
    output logic [DATA_W-1:0] ReadDataW
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              mem_err_q, mem_err_d;

    logic              reg_write_w_q, reg_write_w_d;
    logic              result_src_w_q, result_src_w_d;
    logic [4:0]        rd_w_q, rd_w_d;
    logic [DATA_W-1:0] pc_plus4_w_q, pc_plus4_w_d;
    logic [DATA_W-1:0] alu_result_w_q, alu_result_w_d;
    logic [DATA_W-1:0] read_data_w_q, read_data_w_d;

    logic access;
    logic stall;

    assign access = MemWriteM | ResultSrcM;
    assign stall  = ((state_q == IDLE) && access) || (state_q == BUSY);

    // Access sequencer: the request fields are latched on entry to BUSY and held until exit.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        mem_err_d   = mem_err_q;

        case (state_q)
            IDLE: begin
                if (access) begin
                    mem_addr_d  = ALU_ResultM;
                    mem_wdata_d = WriteDataM;
                    mem_we_d    = MemWriteM;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem.mem_ack) begin
                    // The latched write flag decides load vs store, so a store never captures rdata.
                    mem_req_d = 1'b0;
                    rbuf_d    = mem_we_q ? '0 : mem.mem_rdata;
                    state_d   = DONE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    mem_req_d = 1'b0;
                    rbuf_d    = '0;
                    mem_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // W bundle holds while stalled so the re-applied writeback stays valid for forwarding.
    always_comb begin
        reg_write_w_d  = reg_write_w_q;
        result_src_w_d = result_src_w_q;
        rd_w_d         = rd_w_q;
        pc_plus4_w_d   = pc_plus4_w_q;
        alu_result_w_d = alu_result_w_q;
        read_data_w_d  = read_data_w_q;

        if (!stall) begin
            reg_write_w_d  = RegWriteM;
            result_src_w_d = ResultSrcM;
            rd_w_d         = RD_M;
            pc_plus4_w_d   = PCPlus4M;
            alu_result_w_d = ALU_ResultM;
            read_data_w_d  = (state_q == DONE) ? rbuf_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            cnt_q          <= '0;
            rbuf_q         <= '0;
            mem_err_q      <= 1'b0;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 1'b0;
            rd_w_q         <= '0;
            pc_plus4_w_q   <= '0;
            alu_result_w_q <= '0;
            read_data_w_q  <= '0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cnt_q          <= cnt_d;
            rbuf_q         <= rbuf_d;
            mem_err_q      <= mem_err_d;
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            rd_w_q         <= rd_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign StallM      = stall;
    assign mem_err     = mem_err_q;
    assign RegWriteW   = reg_write_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign RD_W        = rd_w_q;
    assign PCPlus4W    = pc_plus4_w_q;
    assign ALU_ResultW = alu_result_w_q;
    assign ReadDataW   = read_data_w_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: the driver queues expected W bundles and memory
// requests, a responder plays data memory, and a monitor pops and compares.
module tb_memory_cycle;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        StallM, mem_err, RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    memory_cycle_if #(.DATA_W(32)) mif ();

    memory_cycle #(.DATA_W(32), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RD_M       (RD_M),
        .PCPlus4M   (PCPlus4M),
        .WriteDataM (WriteDataM),
        .ALU_ResultM(ALU_ResultM),
        .mem        (mif.master),
        .StallM     (StallM),
        .mem_err    (mem_err),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RD_W       (RD_W),
        .PCPlus4W   (PCPlus4W),
        .ALU_ResultW(ALU_ResultW),
        .ReadDataW  (ReadDataW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        rs;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } w_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } req_exp_t;

    w_exp_t      w_q[$];
    req_exp_t    req_q[$];
    int          lat_q[$];
    logic [31:0] rdat_q[$];

    int errors = 0;
    int checks = 0;

    logic        m_valid  = 1'b0;
    logic        resp_ack = 1'b0;
    logic        late_ack = 1'b0;
    logic [31:0] cur_rd   = '0;

    assign mif.mem_ack   = resp_ack | late_ack;
    assign mif.mem_rdata = resp_ack ? cur_rd : 32'hA5A5_5A5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory: acks in the lat-th cycle of a request; lat 0 never acks.
    int resp_lat = 0;
    int resp_cnt = 0;
    bit resp_active = 0;
    always begin
        @(posedge clk);
        #1;
        resp_ack = 1'b0;
        if (mif.mem_req === 1'b1 && !resp_active) begin
            resp_active = 1;
            resp_cnt    = 1;
            resp_lat    = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            cur_rd      = (rdat_q.size() != 0) ? rdat_q.pop_front() : 32'h0;
        end else if (mif.mem_req === 1'b1) begin
            resp_cnt++;
        end else begin
            resp_active = 0;
        end
        if (resp_active && resp_lat != 0 && resp_cnt == resp_lat) resp_ack = 1'b1;
    end

    // Monitor: W bundle one cycle after each advance, request fields and length.
    bit       adv_pending = 0;
    int       adv_stalls  = 0;
    int       stall_cnt   = 0;
    bit       req_prev    = 0;
    int       req_len     = 0;
    req_exp_t cur_req;
    always @(negedge clk) begin
        if (adv_pending) begin
            adv_pending = 0;
            if (w_q.size() == 0) begin
                chk("w_unexpected", 32'd1, 32'd0);
            end else begin
                w_exp_t e;
                e = w_q.pop_front();
                $display("W   rd=%0d alu=0x%08h rdata=0x%08h stalls=%0d err=%0b", RD_W, ALU_ResultW, ReadDataW, adv_stalls, mem_err);
                chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, e.rw});
                chk("ResultSrcW", {31'd0, ResultSrcW}, {31'd0, e.rs});
                chk("RD_W", {27'd0, RD_W}, {27'd0, e.rd});
                chk("PCPlus4W", PCPlus4W, e.pc);
                chk("ALU_ResultW", ALU_ResultW, e.alu);
                chk("ReadDataW", ReadDataW, e.rdata);
                chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
                chk("stall_cycles", 32'(adv_stalls), 32'(e.stalls));
            end
        end
        if (rst === 1'b1) begin
            stall_cnt = 0;
        end else if (m_valid) begin
            if (StallM) begin
                stall_cnt++;
            end else begin
                adv_pending = 1;
                adv_stalls  = stall_cnt;
                stall_cnt   = 0;
            end
        end
        if (mif.mem_req === 1'b1 && !req_prev) begin
            if (req_q.size() == 0) begin
                chk("req_unexpected", 32'd1, 32'd0);
                cur_req = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, len: 0};
            end else begin
                cur_req = req_q.pop_front();
                chk("mem_addr", mif.mem_addr, cur_req.addr);
                chk("mem_we", {31'd0, mif.mem_we}, {31'd0, cur_req.we});
                if (cur_req.we) chk("mem_wdata", mif.mem_wdata, cur_req.wdata);
            end
            req_len = 1;
        end else if (mif.mem_req === 1'b1) begin
            req_len++;
            chk("mem_addr_hold", mif.mem_addr, cur_req.addr);
        end else if (req_prev) begin
            $display("REQ addr=0x%08h we=%0b len=%0d", cur_req.addr, cur_req.we, req_len);
            chk("req_len", 32'(req_len), 32'(cur_req.len));
        end
        req_prev = (mif.mem_req === 1'b1);
    end

    task automatic set_m(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        RD_M        = rd;
        PCPlus4M    = pc;
        WriteDataM  = wd;
        ALU_ResultM = alu;
    endtask

    // Issue one instruction with hand-computed expectations and hold it until it advances.
    task automatic issue(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu,
                         input int lat, input logic [31:0] rdata,
                         input logic [31:0] exp_rdata, input int exp_stalls, input int exp_len,
                         input logic exp_err);
        int k;
        if (mw | rs) begin
            lat_q.push_back(lat);
            rdat_q.push_back(rdata);
            req_q.push_back('{addr: alu, we: mw, wdata: wd, len: exp_len});
        end
        w_q.push_back('{rw: rw, rs: rs, rd: rd, pc: pc, alu: alu, rdata: exp_rdata,
                        err: exp_err, stalls: exp_stalls});
        set_m(rw, mw, rs, rd, pc, wd, alu);
        m_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (StallM && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("advance_timeout", 32'(k), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_mem_addr", mif.mem_addr, 32'd0);
        chk("rst_StallM", {31'd0, StallM}, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_RD_W", {27'd0, RD_W}, 32'd0);
        chk("rst_ReadDataW", ReadDataW, 32'd0);
        @(posedge clk);
        #1;

        //    rw    mw    rs    rd     pc            wd            alu           lat rdata         exp_rdata     stl len err
        issue(1'b1, 1'b0, 1'b0, 5'd5,  32'h0000_1004, 32'h0,        32'h0000_0010, 0, 32'h0,        32'h0,        0, 0, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 5'd6,  32'h0000_1008, 32'h0,        32'h0000_0100, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 2, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_100C, 32'hCAFE_F00D, 32'h0000_0200, 1, 32'h1111_2222, 32'h0,        2, 1, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_1010, 32'h0,        32'h0000_0104, 1, 32'h0123_4567, 32'h0123_4567, 2, 1, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_1014, 32'h55AA_55AA, 32'h0000_0208, 1, 32'h7777_7777, 32'h0,        2, 1, 1'b0);
        issue(1'b0, 1'b1, 1'b1, 5'd9,  32'h0000_1018, 32'h0BAD_F00D, 32'h0000_020C, 3, 32'h9999_9999, 32'h0,        4, 3, 1'b0);
        issue(1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_101C, 32'h0,        32'hFFFF_FFFC, 0, 32'h0,        32'h0,        0, 0, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_1020, 32'h0,        32'h0000_0300, 0, 32'h0,        32'h0,        5, 4, 1'b1);
        issue(1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_1024, 32'h0,        32'h0000_0040, 0, 32'h0,        32'h0,        0, 0, 1'b1);

        // Reset while BUSY: request is abandoned and the W bundle clears.
        m_valid = 1'b0;
        lat_q.push_back(10);
        rdat_q.push_back(32'h0);
        req_q.push_back('{addr: 32'h0000_0400, we: 1'b0, wdata: 32'h0, len: 2});
        set_m(1'b1, 1'b0, 1'b1, 5'd14, 32'h0000_1028, 32'h0, 32'h0000_0400);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        $display("RST mid-access: mem_req=%0b StallM=%0b RD_W=%0d", mif.mem_req, StallM, RD_W);
        chk("rstb_mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rstb_StallM_access", {31'd0, StallM}, 32'd1);
        chk("rstb_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        chk("rstb_RD_W", {27'd0, RD_W}, 32'd0);
        chk("rstb_ALU_ResultW", ALU_ResultW, 32'd0);
        chk("rstb_PCPlus4W", PCPlus4W, 32'd0);
        chk("rstb_mem_err", {31'd0, mem_err}, 32'd0);
        set_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("rstb_StallM_idle", {31'd0, StallM}, 32'd0);
        @(posedge clk);
        #1;
        late_ack = 1'b1;
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("late_ack_StallM", {31'd0, StallM}, 32'd0);
        chk("late_ack_ReadDataW", ReadDataW, 32'd0);
        @(posedge clk);
        #1;

        issue(1'b1, 1'b0, 1'b0, 5'd13, 32'h0000_102C, 32'h0, 32'h0000_0044, 0, 32'h0, 32'h0, 0, 0, 1'b0);

        m_valid = 1'b0;
        set_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("w_queue_drained", 32'(w_q.size()), 32'd0);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
Memory-access pipeline stage. It consumes the M-stage bundle produced by the execute stage (control bits, destination register, PC+4, store data, ALU result) and performs loads and stores over a req/ack data-memory port with variable latency. While an access is outstanding it raises StallM to the hazard unit. It registers the result bundle into the W stage for writeback.

Parameters:
DATA_W, 32, width of data, address, PCPlus4 and ALU result
TIMEOUT, 255, BUSY cycles without ack before abort (0 = never abort)
CNT_W, 16, timeout counter width (TIMEOUT < 2^CNT_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
RegWriteM  in  1  writeback enable of M instruction
MemWriteM  in  1  store
ResultSrcM  in  1  load (1 = result from memory)
RD_M  in  5  destination register
PCPlus4M  in  DATA_W  PC+4 of M instruction
WriteDataM  in  DATA_W  store data (already forwarded)
ALU_ResultM  in  DATA_W  effective address / ALU result
mem_req  out  1  access request to data memory
mem_we  out  1  1 = write
mem_addr  out  DATA_W  word address (passed unaligned; memory ignores [1:0])
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse
StallM  out  1  freeze PC, F, D, E and M registers
mem_err  out  1  sticky timeout flag
RegWriteW  out  1  registered RegWriteM
ResultSrcW  out  1  registered ResultSrcM
RD_W  out  5  registered RD_M
PCPlus4W  out  DATA_W  registered PCPlus4M
ALU_ResultW  out  DATA_W  registered ALU_ResultM
ReadDataW  out  DATA_W  load data for writeback

Behaviour:
- Reset (rst=1 at posedge): state IDLE; mem_req, mem_we, mem_err, counter, read buffer and all W outputs = 0; mem_addr, mem_wdata = 0. Reset overrides everything, including mid-transaction: mem_req drops on the next cycle.
- access = MemWriteM | ResultSrcM. If both are set, treat it as a store.
- FSM IDLE:
  - If access: latch mem_addr = ALU_ResultM, mem_wdata = WriteDataM, mem_we = MemWriteM; set mem_req <= 1; clear counter; go to BUSY.
  - Otherwise stay in IDLE.
- FSM BUSY:
  - mem_req, mem_addr, mem_wdata and mem_we are held stable.
  - On mem_ack: mem_req <= 0; rbuf <= mem_rdata if load, else 0; go to DONE.
  - Otherwise counter++. When counter reaches TIMEOUT-1 (TIMEOUT != 0) with no ack: mem_req <= 0; rbuf <= 0; mem_err <= 1; go to DONE.
  - If ack and timeout occur in the same cycle, ack wins.
- FSM DONE: one cycle, then IDLE.
- mem_ack seen in IDLE or DONE is ignored.
- StallM (combinational) = (IDLE & access) | BUSY. StallM is 0 in DONE and in IDLE when there is no access.
- Latency:
  - Non-memory instruction: 0 stall cycles.
  - Memory op: stalls for 1 IDLE cycle plus N BUSY cycles, where the ack arrives N cycles after mem_req rises (N≥1). It advances on the DONE cycle.
- W register update at posedge:
  - If StallM=0: load all W outputs from the M inputs. ReadDataW <= rbuf when in DONE, else 0.
  - If StallM=1: hold all W outputs. Holding the W instruction re-applies the same register write, which is harmless, and keeps ResultW valid for forwarding into the stalled E stage.
- Back-to-back memory ops: DONE advances op A. The next cycle is IDLE with op B in M, which starts a new access. Minimum spacing is 3 cycles per op.
- mem_err is cleared only by rst. A timed-out load writes back 0.

Test Plan:
- ALU op: ALU_ResultM=0x0000_0010, RD_M=5, RegWriteM=1, MemWriteM=ResultSrcM=0 -> StallM=0, no mem_req; next cycle RegWriteW=1, RD_W=5, ALU_ResultW=0x10, ReadDataW=0.
- Load with ack 2 cycles after req: ALU_ResultM=0x100, ResultSrcM=1, mem_rdata=0xDEADBEEF -> mem_req high 2 cycles with addr=0x100 and we=0; StallM high 3 cycles; then ReadDataW=0xDEADBEEF, ResultSrcW=1.
- Store with ack in the first BUSY cycle: ALU_ResultM=0x200, WriteDataM=0xCAFEF00D -> mem_we=1, mem_wdata=0xCAFEF00D; StallM high 2 cycles; mem_err=0.
- Timeout with TIMEOUT=4 and a load that never gets an ack -> mem_req high 4 cycles then low; mem_err=1 sticky; ReadDataW=0; pipeline advances.
- Reset in BUSY: rst=1 for one cycle -> next cycle mem_req=0, StallM follows the inputs, all W outputs=0. A late mem_ack afterwards has no effect.
- Back-to-back load then store, each acked after 1 cycle -> the W register captures the load result, then the store. The second mem_req rises the cycle after DONE. StallM pattern is 1,1,0,1,1,0.
